// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller for the 1x3 router.
// Tracks header decode, payload load, FIFO-full stall and parity check, and
// emits Moore strobes for the synchronizer and input register block.
module router_fsm (
   input  logic       clock,
   input  logic       reset,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       write_enb_reg,
   output logic       rst_int_reg,
   output logic       busy
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] addr_q;
   logic       hdr_empty;   // empty flag of the FIFO named by the incoming header
   logic       addr_empty;  // empty flag of the FIFO held in addr_q
   logic       soft_hit;    // timeout reset aimed at the port we are serving

   // Select per-port empty flags and the soft reset of the addressed port.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      hdr_empty  = 1'b0;
      addr_empty = 1'b0;
      soft_hit   = 1'b0;
      case (data_in)
         2'd0:    hdr_empty = fifo_empty_0;
         2'd1:    hdr_empty = fifo_empty_1;
         2'd2:    hdr_empty = fifo_empty_2;
         default: hdr_empty = 1'b0;
      endcase
      case (addr_q)
         2'd0: begin addr_empty = fifo_empty_0; soft_hit = soft_reset_0; end
         2'd1: begin addr_empty = fifo_empty_1; soft_hit = soft_reset_1; end
         2'd2: begin addr_empty = fifo_empty_2; soft_hit = soft_reset_2; end
         default: begin addr_empty = 1'b0; soft_hit = 1'b0; end
      endcase
   end

   // Next-state logic; a matching soft reset overrides every normal transition.
   always_comb begin
      state_next = state;
      if (soft_hit) begin
         state_next = DECODE_ADDRESS;
      end else begin
         case (state)
            DECODE_ADDRESS: begin
               // Address 3 never matches a FIFO, so the header is ignored.
               if (pkt_valid && data_in != 2'd3)
                  state_next = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: state_next = LOAD_DATA;
            LOAD_DATA: begin
               if (fifo_full)       state_next = FIFO_FULL_STATE;
               else if (!pkt_valid) state_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
               if (!fifo_full) state_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (parity_done)        state_next = DECODE_ADDRESS;
               else if (low_pkt_valid) state_next = LOAD_PARITY;
               else                    state_next = LOAD_DATA;
            end
            LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
               state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
               if (addr_empty) state_next = LOAD_FIRST_DATA;
            end
            default: state_next = DECODE_ADDRESS;
         endcase
      end
   end

   // State and latched destination address; reset dominates everything.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (reset) begin
         state  <= DECODE_ADDRESS;
         addr_q <= 2'd0;
      end else begin
         state <= state_next;
         if (state == DECODE_ADDRESS && pkt_valid)
            addr_q <= data_in;
      end
   end

   // Moore outputs decoded from the current state only.
   assign detect_add    = (state == DECODE_ADDRESS);
   assign lfd_state     = (state == LOAD_FIRST_DATA);
   assign ld_state      = (state == LOAD_DATA);
   assign full_state    = (state == FIFO_FULL_STATE);
   assign laf_state     = (state == LOAD_AFTER_FULL);
   assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
   assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                          (state == LOAD_AFTER_FULL);
   assign busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed self-checking bench for router_fsm.
// Output vector order: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}.
module tb_router_fsm;

   logic       clock = 1'b0;
   logic       reset, pkt_valid, fifo_full, parity_done, low_pkt_valid;
   logic [1:0] data_in;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       write_enb_reg, rst_int_reg, busy;

   int checks = 0;
   int errors = 0;

   // Expected output vectors per state, derived from the Moore decode table.
   localparam logic [7:0] O_DEC  = 8'b1000_0000;
   localparam logic [7:0] O_LFD  = 8'b0100_0001;
   localparam logic [7:0] O_LD   = 8'b0010_0100;
   localparam logic [7:0] O_LAF  = 8'b0001_0101;
   localparam logic [7:0] O_FULL = 8'b0000_1001;
   localparam logic [7:0] O_LP   = 8'b0000_0101;
   localparam logic [7:0] O_CPE  = 8'b0000_0011;
   localparam logic [7:0] O_WTE  = 8'b0000_0001;

   router_fsm dut (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full),
      .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
      .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
      .rst_int_reg(rst_int_reg), .busy(busy)
   );

   always #5 clock = ~clock;

   // Advance one rising edge, then settle before sampling or driving.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] exp);
      logic [7:0] obs;
      obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, busy};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_addr(input string tag, input logic [1:0] exp);
      checks++;
      assert (dut.addr_q === exp) else begin
         errors++;
         $error("FAIL %s: observed addr_q %0d expected %0d", tag, dut.addr_q, exp);
      end
   endtask

   initial begin
      reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
      parity_done = 1'b0; low_pkt_valid = 1'b0;
      fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;

      // Reset for two cycles.
      tick(); tick();
      check("reset_outputs", O_DEC);
      check_addr("reset_addr", 2'd0);
      reset = 1'b0;

      // Idle with pkt_valid low.
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle", O_DEC);
      end

      // Normal packet to port 1: LFD, 4 x LD, LP, CPE, DECODE.
      pkt_valid = 1'b1; data_in = 2'd1;
      tick(); check("pkt_lfd", O_LFD);
      check_addr("pkt_addr1", 2'd1);
      for (int i = 0; i < 4; i++) begin
         tick(); check("pkt_ld", O_LD);
      end
      pkt_valid = 1'b0;
      tick(); check("pkt_lp", O_LP);
      tick(); check("pkt_cpe", O_CPE);
      tick(); check("pkt_dec", O_DEC);

      // Busy FIFO on port 2: wait, then proceed once empty.
      pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
      tick(); check("wte_enter", O_WTE);
      for (int i = 0; i < 4; i++) begin
         tick(); check("wte_hold", O_WTE);
      end
      fifo_empty_2 = 1'b1;
      tick(); check("wte_lfd", O_LFD);
      tick(); check("wte_ld", O_LD);

      // FIFO full for 3 sampled cycles, then LAF, then low_pkt_valid -> LP.
      fifo_full = 1'b1;
      tick(); check("full_1", O_FULL);
      tick(); check("full_2", O_FULL);
      tick(); check("full_3", O_FULL);
      fifo_full = 1'b0; low_pkt_valid = 1'b1;
      tick(); check("laf", O_LAF);
      tick(); check("laf_to_lp", O_LP);
      low_pkt_valid = 1'b0; fifo_full = 1'b1;
      tick(); check("lp_cpe", O_CPE);
      // Parity check with the FIFO full goes back to the stall.
      tick(); check("cpe_to_full", O_FULL);
      fifo_full = 1'b0; parity_done = 1'b1;
      tick(); check("laf_b", O_LAF);
      // parity_done wins in LAF.
      tick(); check("laf_parity_done", O_DEC);
      parity_done = 1'b0;

      // New packet on port 0; LAF with low_pkt_valid=0 returns to LD.
      pkt_valid = 1'b1; data_in = 2'd0;
      tick(); check("p0_lfd", O_LFD);
      tick(); check("p0_ld", O_LD);
      fifo_full = 1'b1;
      tick(); check("p0_full", O_FULL);
      fifo_full = 1'b0;
      tick(); check("p0_laf", O_LAF);
      tick(); check("laf_to_ld", O_LD);
      pkt_valid = 1'b0;
      tick(); check("p0_lp", O_LP);
      tick(); check("p0_cpe", O_CPE);
      tick(); check("p0_dec", O_DEC);

      // Soft reset: addr 0 in WAIT; non-matching port ignored, matching one wins.
      pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b0;
      tick(); check("sr_wte", O_WTE);
      check_addr("sr_addr0", 2'd0);
      pkt_valid = 1'b0; soft_reset_1 = 1'b1;
      tick(); check("sr1_ignored", O_WTE);
      soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
      tick(); check("sr0_dec", O_DEC);
      soft_reset_0 = 1'b0; fifo_empty_0 = 1'b1;
      tick(); check("sr0_stay", O_DEC);

      // Invalid header address 3 stays in decode.
      pkt_valid = 1'b1; data_in = 2'd3;
      tick(); check("inv_1", O_DEC);
      tick(); check("inv_2", O_DEC);

      // Matching soft reset mid-LD on port 2.
      data_in = 2'd2;
      tick(); check("sr2_lfd", O_LFD);
      tick(); check("sr2_ld", O_LD);
      soft_reset_2 = 1'b1;
      tick(); check("sr2_dec", O_DEC);
      soft_reset_2 = 1'b0;

      // Reset together with soft_reset_0 mid-LD clears addr_q.
      tick(); check("rp_lfd", O_LFD);
      check_addr("rp_addr2", 2'd2);
      tick(); check("rp_ld", O_LD);
      reset = 1'b1; soft_reset_0 = 1'b1;
      tick(); check("rp_dec", O_DEC);
      check_addr("rp_addr0", 2'd0);
      reset = 1'b0; soft_reset_0 = 1'b0; pkt_valid = 1'b0;
      tick(); check("rp_idle", O_DEC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
